// File: rtl/huffman_code_table_pkg.sv
// Shared constants, FSM state type and the length-bucketed code hash
// used by the Huffman code table.
package huffman_pkg;

   localparam int MAX_LEN   = 12;
   localparam int SHORT_LEN = 7;

   localparam logic [7:0] BASE_L8  = 8'd128;
   localparam logic [7:0] BASE_L9  = 8'd192;
   localparam logic [7:0] BASE_L10 = 8'd224;
   localparam logic [7:0] BASE_L11 = 8'd240;
   localparam logic [7:0] BASE_L12 = 8'd248;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   typedef struct packed {
      logic       legal;
      logic [7:0] idx;
   } hash_t;

   // Each bucket base is aligned to its bucket size, so OR-ing in the path
   // field is the same as adding it.
   function automatic hash_t code_hash(input logic [31:0] len, input logic [11:0] path);
      hash_t h;
      h.legal = 1'b1;
      h.idx   = '0;
      if (len >= 32'd1 && len <= 32'(SHORT_LEN)) begin
         h.idx = {1'b0, path[6:0]};
      end else if (len == 32'd8) begin
         h.idx = BASE_L8 | {2'b00, path[8:3]};
      end else if (len == 32'd9) begin
         h.idx = BASE_L9 | {3'b000, path[9:5]};
      end else if (len == 32'd10) begin
         h.idx = BASE_L10 | {4'b0000, path[10:7]};
      end else if (len == 32'd11) begin
         h.idx = BASE_L11 | {5'b00000, path[11:9]};
      end else if (len == 32'(MAX_LEN)) begin
         h.idx = BASE_L12 | {6'b000000, path[11:10]};
      end else begin
         h.legal = 1'b0;
      end
      return h;
   endfunction

endpackage

// File: rtl/huffman_code_table_if.sv
// Request/response bundle between the code table and its writer/reader.
interface huffman_code_table_if #(
   parameter int CHAR_W = 8,
   parameter int PATH_W = 12,
   parameter int LEN_W  = 4,
   parameter int ADDR_W = 8
);
   logic              clear_start;
   logic              busy;
   logic              wr_en;
   logic [LEN_W-1:0]  wr_len;
   logic [PATH_W-1:0] wr_path;
   logic [CHAR_W-1:0] wr_char;
   logic              wr_done;
   logic              wr_collision;
   logic              wr_error;
   logic              rd_en;
   logic [LEN_W-1:0]  rd_len;
   logic [PATH_W-1:0] rd_path;
   logic              rd_valid;
   logic              rd_hit;
   logic [CHAR_W-1:0] rd_char;
   logic [ADDR_W:0]   entry_count;

   modport master (
      output clear_start, wr_en, wr_len, wr_path, wr_char, rd_en, rd_len, rd_path,
      input  busy, wr_done, wr_collision, wr_error, rd_valid, rd_hit, rd_char, entry_count
   );

   modport slave (
      input  clear_start, wr_en, wr_len, wr_path, wr_char, rd_en, rd_len, rd_path,
      output busy, wr_done, wr_collision, wr_error, rd_valid, rd_hit, rd_char, entry_count
   );
endinterface

// File: rtl/huffman_code_table_mem.sv
// Character storage plus per-entry valid bits: one write port, one registered
// (read-before-write) read port and a single-index valid clear.
module code_table_mem #(
   parameter int CHAR_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [CHAR_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   output logic              wvalid_o,
   output logic              rvalid_o,
   output logic [CHAR_W-1:0] rdata_o
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [CHAR_W-1:0] mem_q [DEPTH];
   logic [CHAR_W-1:0] rdata_q;
   logic [DEPTH-1:0]  valid_q;
   logic              rvalid_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   // Valid bits live in flops so reset can wipe the whole table at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         if (re_i)  rvalid_q <= valid_q[raddr_i];
         if (we_i)  valid_q[waddr_i] <= 1'b1;
         if (clr_i) valid_q[clr_addr_i] <= 1'b0;
      end
   end

   assign wvalid_o = valid_q[waddr_i];
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
endmodule

// File: rtl/huffman_code_table.sv
// Hashed Huffman code table: write/lookup by (length, path), with collision and
// illegal-length flags, occupancy count and a sequential clear sweep.
module huffman_code_table
   import huffman_pkg::*;
#(
   parameter int CHAR_W = 8,
   parameter int PATH_W = 12,
   parameter int LEN_W  = 4,
   parameter int ADDR_W = 8
) (
   input logic                 clk,
   input logic                 rst,
   huffman_code_table_if.slave bus
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] sweep_q, sweep_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              wr_done_q, wr_coll_q, wr_err_q;
   logic              rd_valid_q, rd_legal_q;

   logic [LEN_W-1:0]  wr_len, rd_len;
   logic [PATH_W-1:0] wr_path, rd_path;
   hash_t             wr_h, rd_h;
   logic              idle, wr_ok, wr_bad, rd_go;
   logic              mem_wvalid, mem_rvalid, rd_hit;
   logic [CHAR_W-1:0] mem_rdata;

   assign wr_len  = bus.wr_len;
   assign rd_len  = bus.rd_len;
   assign wr_path = bus.wr_path;
   assign rd_path = bus.rd_path;
   assign wr_h    = code_hash(32'(wr_len), wr_path[11:0]);
   assign rd_h    = code_hash(32'(rd_len), rd_path[11:0]);

   assign idle   = (state_q == IDLE);
   assign wr_ok  = idle && bus.wr_en && wr_h.legal;
   assign wr_bad = idle && bus.wr_en && !wr_h.legal;
   assign rd_go  = idle && bus.rd_en;

   code_table_mem #(
      .CHAR_W (CHAR_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk        (clk),
      .rst        (rst),
      .we_i       (wr_ok),
      .waddr_i    (wr_h.idx),
      .wdata_i    (bus.wr_char),
      .re_i       (rd_go && rd_h.legal),
      .raddr_i    (rd_h.idx),
      .clr_i      (state_q == CLEAR),
      .clr_addr_i (sweep_q),
      .wvalid_o   (mem_wvalid),
      .rvalid_o   (mem_rvalid),
      .rdata_o    (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (wr_ok && !mem_wvalid) count_d = count_q + 1'b1;
            // A write in the same cycle lands first, then the sweep discards it.
            if (bus.clear_start) begin
               state_d = CLEAR;
               sweep_d = '0;
               count_d = '0;
            end
         end
         CLEAR: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sweep_q    <= '0;
         count_q    <= '0;
         wr_done_q  <= 1'b0;
         wr_coll_q  <= 1'b0;
         wr_err_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_legal_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         count_q    <= count_d;
         wr_done_q  <= wr_ok;
         wr_coll_q  <= wr_ok && mem_wvalid;
         wr_err_q   <= wr_bad;
         rd_valid_q <= rd_go;
         rd_legal_q <= rd_go && rd_h.legal;
      end
   end

   assign rd_hit = rd_valid_q && rd_legal_q && mem_rvalid;

   assign bus.busy         = (state_q == CLEAR);
   assign bus.wr_done      = wr_done_q;
   assign bus.wr_collision = wr_coll_q;
   assign bus.wr_error     = wr_err_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_hit       = rd_hit;
   assign bus.rd_char      = rd_hit ? mem_rdata : '0;
   assign bus.entry_count  = count_q;
endmodule

// File: tb/tb_huffman_code_table.sv
// Randomised scoreboard bench for huffman_code_table against an array-based
// reference table indexed by an arithmetic form of the bucket hash.
module tb_huffman_code_table;
   localparam int CHAR_W = 8;
   localparam int PATH_W = 12;
   localparam int LEN_W  = 4;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   huffman_code_table_if #(.CHAR_W(CHAR_W), .PATH_W(PATH_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

   huffman_code_table #(.CHAR_W(CHAR_W), .PATH_W(PATH_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { int due; bit hit; int ch; } rd_exp_t;
   typedef struct { int due; bit coll; bit err; } wr_exp_t;

   rd_exp_t rdq[$];
   wr_exp_t wrq[$];
   int      n_vec = 0;
   int      n_bad = 0;
   int      cyc   = 0;

   bit      ref_valid [256];
   int      ref_char  [256];
   int      ref_count;
   int      busy_left;
   int      code_len[$];
   int      code_path[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, longint act, longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Table index from the bucket rules; -1 for an illegal length.
   function automatic int ref_idx(int len, int path);
      int lsb;
      if (len >= 1 && len <= 7) return path % 128;
      if (len < 8 || len > 12) return -1;
      lsb = (len == 12) ? 10 : 2 * len - 13;
      return (256 - (256 >> (len - 7))) + ((path >> lsb) % (1 << (14 - len)));
   endfunction

   task automatic model_reset();
      foreach (ref_valid[i]) ref_valid[i] = 1'b0;
      ref_count = 0;
      busy_left = 0;
      rdq.delete();
      wrq.delete();
   endtask

   task automatic step(bit we, int wl, int wp, int wc, bit re, int rl, int rp, bit cs);
      int ri, wi;
      @(negedge clk);
      chk("busy", bus.busy, busy_left > 0);
      chk("entry_count", bus.entry_count, ref_count);
      bus.wr_en       = we;
      bus.wr_len      = LEN_W'(wl);
      bus.wr_path     = PATH_W'(wp);
      bus.wr_char     = CHAR_W'(wc);
      bus.rd_en       = re;
      bus.rd_len      = LEN_W'(rl);
      bus.rd_path     = PATH_W'(rp);
      bus.clear_start = cs;
      if (busy_left > 0) begin
         busy_left--;
      end else begin
         if (re) begin
            ri = ref_idx(rl, rp);
            if (ri >= 0 && ref_valid[ri]) rdq.push_back('{cyc + 1, 1'b1, ref_char[ri]});
            else                          rdq.push_back('{cyc + 1, 1'b0, 0});
         end
         if (we) begin
            wi = ref_idx(wl, wp);
            if (wi >= 0) begin
               wrq.push_back('{cyc + 1, ref_valid[wi], 1'b0});
               if (!ref_valid[wi]) ref_count++;
               ref_valid[wi] = 1'b1;
               ref_char[wi]  = wc % 256;
            end else begin
               wrq.push_back('{cyc + 1, 1'b0, 1'b1});
            end
         end
         if (cs) begin
            foreach (ref_valid[i]) ref_valid[i] = 1'b0;
            ref_count = 0;
            busy_left = 256;
         end
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin : monitor
      rd_exp_t re_e;
      wr_exp_t we_e;
      if (!rst) begin
         if (rdq.size() > 0 && rdq[0].due == cyc) begin
            re_e = rdq.pop_front();
            chk("rd_valid", bus.rd_valid, 1);
            chk("rd_hit", bus.rd_hit, re_e.hit);
            chk("rd_char", bus.rd_char, re_e.ch);
         end else begin
            chk("rd_quiet", {bus.rd_valid, bus.rd_hit, bus.rd_char}, 0);
         end
         if (wrq.size() > 0 && wrq[0].due == cyc) begin
            we_e = wrq.pop_front();
            chk("wr_done", bus.wr_done, !we_e.err);
            chk("wr_collision", bus.wr_collision, we_e.coll);
            chk("wr_error", bus.wr_error, we_e.err);
         end else begin
            chk("wr_quiet", {bus.wr_done, bus.wr_collision, bus.wr_error}, 0);
         end
      end
   end

   initial begin
      int fl[10];
      int fp[10];
      rst             = 1'b1;
      bus.clear_start = 1'b0;
      bus.wr_en       = 1'b0;
      bus.wr_len      = '0;
      bus.wr_path     = '0;
      bus.wr_char     = '0;
      bus.rd_en       = 1'b0;
      bus.rd_len      = '0;
      bus.rd_path     = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_count", bus.entry_count, 0);
      chk("rst_rd", {bus.rd_valid, bus.rd_hit, bus.rd_char}, 0);
      chk("rst_wr", {bus.wr_done, bus.wr_collision, bus.wr_error}, 0);
      rst = 1'b0;

      // Basic write then lookup.
      step(1, 5, 'h013, 'h41, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 5, 'h013, 0);
      // Overwrite at idx 159 reports a collision.
      step(1, 8, 'h0F8, 'h5A, 0, 0, 0, 0);
      step(1, 8, 'h0F8, 'h62, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 8, 'h0F8, 0);
      // Illegal lengths.
      step(1, 0, 'h123, 'h11, 0, 0, 0, 0);
      step(1, 13, 'h123, 'h22, 1, 13, 'h123, 0);
      step(0, 0, 0, 0, 1, 15, 'hFFF, 0);
      // Same-cycle write and read of idx 250 returns the old (empty) entry.
      step(1, 12, 'h800, 'h77, 1, 12, 'h800, 0);
      step(0, 0, 0, 0, 1, 12, 'h800, 0);
      idle(2);

      // Random full-throughput traffic.
      for (int i = 0; i < 500; i++) begin
         int wl, wp, rl, rp, k;
         wl = $urandom_range(0, 15);
         wp = $urandom_range(0, 4095);
         if (code_len.size() > 0 && ($urandom % 2) == 1) begin
            k  = $urandom_range(0, code_len.size() - 1);
            rl = code_len[k];
            rp = code_path[k];
         end else begin
            rl = $urandom_range(0, 15);
            rp = $urandom_range(0, 4095);
         end
         code_len.push_back(wl);
         code_path.push_back(wp);
         step($urandom % 2, wl, wp, $urandom_range(0, 255), $urandom % 2, rl, rp, 0);
      end
      idle(2);

      // Fill, clear, then confirm everything misses.
      for (int i = 0; i < 10; i++) begin
         fl[i] = $urandom_range(1, 12);
         fp[i] = $urandom_range(0, 4095);
         step(1, fl[i], fp[i], $urandom_range(0, 255), 0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 256; i++)
         step($urandom % 2, $urandom_range(1, 12), $urandom_range(0, 4095), $urandom_range(0, 255),
              $urandom % 2, $urandom_range(1, 12), $urandom_range(0, 4095), $urandom % 2);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, fl[i], fp[i], 0);
      idle(2);

      // Clear entered together with a write and read, then reset mid-sweep.
      for (int i = 0; i < 5; i++)
         step(1, $urandom_range(1, 12), $urandom_range(0, 4095), $urandom_range(0, 255), 0, 0, 0, 0);
      step(1, 9, 'h3E0, 'h99, 1, fl[0], fp[0], 1);
      idle(100);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_count", bus.entry_count, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1, 9, 'h3E0, 'hA5, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 9, 'h3E0, 0);
      step(0, 0, 0, 0, 1, 5, 'h013, 0);
      idle(3);

      chk("rd_queue_drained", rdq.size(), 0);
      chk("wr_queue_drained", wrq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
